// File: rtl/detector_paso_ir.sv
// detector_paso_ir
//   Front end of the people counter. Conditions the two raw infrared beams
//   (A = outer, B = inner), tracks each crossing with a direction FSM and
//   emits one single-cycle pulse per complete crossing.
//
//   Build option: define AFORO_EN to add the saturating occupancy counter
//   (parameter OCC_W and output ocupacion). Without it that logic is absent.
//
//   Ports
//     clk        system clock
//     rst_n      asynchronous active-low reset
//     ir_a       raw outer beam, 1 = broken, asynchronous to clk
//     ir_b       raw inner beam, 1 = broken, asynchronous to clk
//     entrada    one-cycle pulse per valid A->B crossing
//     salida     one-cycle pulse per valid B->A crossing
//     error_seq  one-cycle pulse when a crossing is aborted or times out
//     ocupado    high while the FSM is not in IDLE
//     ocupacion  occupancy count (AFORO_EN only)
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   IDLE       | both beams clear, no crossing in progress
//   A1         | entering: only outer beam broken
//   AB_IN      | entering: both beams broken
//   B2         | entering: only inner beam broken
//   B1         | leaving: only inner beam broken
//   AB_OUT     | leaving: both beams broken
//   A2         | leaving: only outer beam broken
//   WAIT_CLEAR | invalid or timed-out crossing, wait for both clear

module detector_paso_ir #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 5000000,
  parameter int TIMER_W         = 23
`ifdef AFORO_EN
  , parameter int OCC_W         = 8
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ir_a,
  input  logic ir_b,
  output logic entrada,
  output logic salida,
  output logic error_seq,
  output logic ocupado
`ifdef AFORO_EN
  , output logic [OCC_W-1:0] ocupacion
`endif
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0]    DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, A1, AB_IN, B2, B1, AB_OUT, A2, WAIT_CLEAR
  } state_t;

  typedef enum logic [1:0] {EV_NONE, EV_ENT, EV_SAL, EV_ERR} ev_t;

  // index 0 = beam A, index 1 = beam B
  logic [1:0]      sync1, sync2, db;
  logic [DB_W-1:0] db_cnt [2];

  state_t           st, st_nxt;
  ev_t              ev;
  logic [TIMER_W-1:0] timer;
  logic a, b;

  assign a = db[0];
  assign b = db[1];

  // Synchronizer and debounce. The counter only runs while the synced level
  // disagrees with the debounced one; DEBOUNCE_CYCLES disagreeing cycles in a
  // row flip the debounced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= {ir_b, ir_a};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Next-state decode; a real beam transition always wins over the timeout.
  always_comb begin
    st_nxt = st;
    ev     = EV_NONE;
    unique case (st)
      IDLE: begin
        if (a && !b)      st_nxt = A1;
        else if (!a && b) st_nxt = B1;
        else if (a && b)  begin st_nxt = WAIT_CLEAR; ev = EV_ERR; end
      end
      A1: begin
        if (a && b)        st_nxt = AB_IN;
        else if (!a && !b) st_nxt = IDLE;
        else if (!a && b)  begin st_nxt = WAIT_CLEAR; ev = EV_ERR; end
      end
      AB_IN: begin
        if (!a && b)       st_nxt = B2;
        else if (a && !b)  st_nxt = A1;
        else if (!a && !b) begin st_nxt = IDLE; ev = EV_ERR; end
      end
      B2: begin
        if (!a && !b)     begin st_nxt = IDLE; ev = EV_ENT; end
        else if (a && b)  st_nxt = AB_IN;
        else if (a && !b) begin st_nxt = WAIT_CLEAR; ev = EV_ERR; end
      end
      B1: begin
        if (a && b)        st_nxt = AB_OUT;
        else if (!a && !b) st_nxt = IDLE;
        else if (a && !b)  begin st_nxt = WAIT_CLEAR; ev = EV_ERR; end
      end
      AB_OUT: begin
        if (a && !b)       st_nxt = A2;
        else if (!a && b)  st_nxt = B1;
        else if (!a && !b) begin st_nxt = IDLE; ev = EV_ERR; end
      end
      A2: begin
        if (!a && !b)     begin st_nxt = IDLE; ev = EV_SAL; end
        else if (a && b)  st_nxt = AB_OUT;
        else if (!a && b) begin st_nxt = WAIT_CLEAR; ev = EV_ERR; end
      end
      WAIT_CLEAR: begin
        if (!a && !b) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase

    if (st_nxt == st && st != IDLE && st != WAIT_CLEAR && timer == TMO_LAST) begin
      st_nxt = WAIT_CLEAR;
      ev     = EV_ERR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      timer     <= '0;
      entrada   <= 1'b0;
      salida    <= 1'b0;
      error_seq <= 1'b0;
      ocupado   <= 1'b0;
    end else begin
      st        <= st_nxt;
      entrada   <= (ev == EV_ENT);
      salida    <= (ev == EV_SAL);
      error_seq <= (ev == EV_ERR);
      ocupado   <= (st_nxt != IDLE);
      // WAIT_CLEAR keeps counting, but the decode above never fires there.
      if (st_nxt != st || st_nxt == IDLE) timer <= '0;
      else                                timer <= timer + TIMER_W'(1);
    end
  end

`ifdef AFORO_EN
  // Updated on the same edge that raises the pulse it counts; saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ocupacion <= '0;
    end else if (ev == EV_ENT && ocupacion != '1) begin
      ocupacion <= ocupacion + OCC_W'(1);
    end else if (ev == EV_SAL && ocupacion != '0) begin
      ocupacion <= ocupacion - OCC_W'(1);
    end
  end
`endif

endmodule
